instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- DEPTH, 16: program memory words; power of two.
- SLOT_CYCLES, 4: clock cycles each instruction is held on iin; range 2..16.
- HALT_WORD, 16'hFFFF: program word that ends a run.
- NOP_WORD, 16'h0000: value driven on iin when no instruction is issued.
REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- clock, input, 1: single clock; all state changes on rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- start, input, 1: begins a run at address 0; honoured only in IDLE or DONE.
- load_en, input, 1: program memory write strobe.
- load_addr, input, log2(DEPTH): write address.
- load_data, input, 16: write data.
- iin, output, 16: instruction word to the processor.
- bus_in, input, 16: processor bus value to capture.
- result_valid, output, 1: result FIFO not empty.
- result_data, output, 16: FIFO head.
- result_ready, input, 1: consumer pop; a pop occurs when result_valid and result_ready are both 1.
- busy, output, 1: state is ISSUE or STALL.
- done, output, 1: state is DONE.
- pc, output, log2(DEPTH): current program address.
- drop_cnt, output, 8: dropped-result count (see Configuration).

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, STALL and DONE.
REQ-004 IDLE/DONE with start=1 SHALL set pc=0 and slot=0, and go to ISSUE, or to DONE if mem[0]==HALT_WORD.
REQ-005 In ISSUE, iin SHALL equal mem[pc] combinationally; in all other states iin SHALL equal NOP_WORD.
REQ-006 In ISSUE, the slot counter SHALL count 0..SLOT_CYCLES-1; bus_in SHALL be sampled on the cycle where slot==SLOT_CYCLES-1.
REQ-007 At the sampling edge, if the FIFO has space (count<4, or a pop occurs in the same cycle), the sample SHALL be pushed, pc incremented and slot cleared.
REQ-008 If the FIFO is full with no pop at the sampling edge, the sample SHALL be held in a hold register and the FSM SHALL enter STALL, with pc and slot frozen.
REQ-009 In STALL, on the first cycle with space, the hold register SHALL be pushed, pc incremented and the FSM SHALL return to ISSUE.
REQ-010 When pc advances to a word equal to HALT_WORD, or past address DEPTH-1 (wrap), the FSM SHALL enter DONE instead of ISSUE; pc SHALL then hold the halting or wrapped value.
REQ-011 The result FIFO SHALL be 4 deep, first-word-fall-through; result_valid SHALL rise the cycle after the first push.
REQ-012 Simultaneous push and pop SHALL leave the count unchanged in every fill state.
REQ-013 Writes with load_en=1 SHALL take effect only in IDLE or DONE; writes while busy=1 SHALL be ignored.
REQ-014 start while busy=1 SHALL be ignored.
REQ-015 A load and a start in the same cycle SHALL apply the write first; a run starting at address 0 SHALL see the new word.

Reset
REQ-016 resetn=0 SHALL asynchronously force: state=IDLE, pc=0, slot=0, FIFO empty, result_valid=0, busy=0, done=0, iin=NOP_WORD, drop_cnt=0.
REQ-017 Program memory contents SHALL be unaffected by reset.
REQ-018 Reset asserted mid-run SHALL discard the hold register and all FIFO contents.

Configuration
REQ-019 With INSTR_SEQ_DROP_EN defined:
- STALL SHALL never be entered.
- A sample arriving with the FIFO full and no pop SHALL be discarded; pc advances normally.
- drop_cnt SHALL increment per discard, saturating at 255, cleared only by reset.
REQ-020 With INSTR_SEQ_DROP_EN undefined, the stall behaviour of REQ-008/009 SHALL apply and drop_cnt SHALL be constant 0.

Verification
REQ-021 Bench SHALL cover the following scenarios:
- Basic run: load mem[0..2]=16'h1001,16'h2002,16'hFFFF, SLOT_CYCLES=4, start, result_ready=1 -> iin shows 16'h1001 for 4 cycles, then 16'h2002 for 4 cycles; two results popped; done=1 with pc=2.
- Full FIFO: 6-instruction program, result_ready=0 -> after 4 pushes busy=1 and state STALL, iin=NOP_WORD; raise result_ready -> remaining 2 results delivered in order; done=1.
- Drop mode: INSTR_SEQ_DROP_EN defined, same program as Full FIFO -> no stall; drop_cnt=2; FIFO holds the first 4 samples.
- Wrap: all 16 words non-halt -> DONE after pc wraps from 15; exactly 16 results produced.
- Reset mid-run: resetn=0 during slot 2 of instruction 1 -> iin=NOP_WORD, result_valid=0 immediately; memory intact; rerun gives identical results.
- Load while busy: load_en to address 1 during a run is ignored; the same write in DONE is applied.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: issues program words on iin for SLOT_CYCLES each and captures bus_in into a 4-deep FWFT FIFO.
// Optional INSTR_SEQ_DROP_EN: discard samples on a full FIFO instead of stalling.
module instr_sequencer #(
    parameter int          DEPTH       = 16,
    parameter int          SLOT_CYCLES = 4,
    parameter logic [15:0] HALT_WORD   = 16'hFFFF,
    parameter logic [15:0] NOP_WORD    = 16'h0000
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [15:0]              load_data,
    output logic [15:0]              iin,
    input  logic [15:0]              bus_in,
    output logic                     result_valid,
    output logic [15:0]              result_data,
    input  logic                     result_ready,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SLOT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, STALL, DONE} state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [SW-1:0] slot;
    logic [15:0]   fifo [4];
    logic [1:0]    rd_ptr, wr_ptr;
    logic [2:0]    count;

    logic          idle_like, wr_ok, pop, space, sample, stall_push, push, advance;
    logic          wrap, halt_nxt, start_halt;
    logic [AW-1:0] pc_nxt;
    logic [15:0]   push_data;

    assign idle_like    = (state == IDLE) || (state == DONE);
    assign wr_ok        = load_en && idle_like;
    assign result_valid = (count != 3'd0);
    assign result_data  = fifo[rd_ptr];
    assign pop          = result_valid && result_ready;
    assign space        = (count != 3'd4) || pop;
    assign sample       = (state == ISSUE) && (slot == SW'(SLOT_CYCLES - 1));
    assign pc_nxt       = pc + AW'(1);
    assign wrap         = (pc == AW'(DEPTH - 1));
    assign halt_nxt     = (mem[pc_nxt] == HALT_WORD);
    // A same-cycle load to address 0 must be visible to the start decision.
    assign start_halt   = ((wr_ok && load_addr == '0) ? load_data : mem[0]) == HALT_WORD;

    assign iin  = (state == ISSUE) ? mem[pc] : NOP_WORD;
    assign busy = (state == ISSUE) || (state == STALL);
    assign done = (state == DONE);

`ifdef INSTR_SEQ_DROP_EN
    assign stall_push = 1'b0;
    assign push       = sample && space;
    assign push_data  = bus_in;
    assign advance    = sample;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            drop_cnt <= 8'd0;
        else if (sample && !space && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`else
    logic [15:0] hold;

    assign stall_push = (state == STALL) && space;
    assign push       = (sample && space) || stall_push;
    assign push_data  = (state == STALL) ? hold : bus_in;
    assign advance    = (sample && space) || stall_push;
    assign drop_cnt   = 8'd0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            hold <= 16'd0;
        else if (sample && !space)
            hold <= bus_in;
    end
`endif

    // Program memory is intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_ok)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'd0, push} - {2'd0, pop};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            pc    <= '0;
            slot  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pc    <= '0;
                        slot  <= '0;
                        state <= start_halt ? DONE : ISSUE;
                    end
                end
                ISSUE, STALL: begin
                    if (advance) begin
                        pc    <= pc_nxt;
                        slot  <= '0;
                        state <= (wrap || halt_nxt) ? DONE : ISSUE;
                    end else if (sample) begin
                        state <= STALL;
                    end else if (state == ISSUE) begin
                        slot <= slot + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; bus_in is modelled as iin ^ 16'h5A5A.
// Define INSTR_SEQ_DROP_EN for both files to check the drop build.
module tb_instr_sequencer;
    logic        clock = 1'b0;
    logic        resetn;
    logic        start, load_en, result_ready;
    logic [3:0]  load_addr;
    logic [15:0] load_data, iin, bus_in, result_data;
    logic        result_valid, busy, done;
    logic [3:0]  pc;
    logic [7:0]  drop_cnt;

    int n_asrt = 0;
    int n_fail = 0;
    logic [15:0] got [$];

    instr_sequencer dut (
        .clock(clock), .resetn(resetn), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .iin(iin), .bus_in(bus_in),
        .result_valid(result_valid), .result_data(result_data),
        .result_ready(result_ready), .busy(busy), .done(done), .pc(pc),
        .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;
    assign bus_in = iin ^ 16'h5A5A;

    function automatic logic [15:0] res(input logic [15:0] w);
        return w ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Record a pop that the coming edge will perform, then advance one cycle.
    task automatic tick();
        if (result_valid && result_ready)
            got.push_back(result_data);
        @(negedge clock);
    endtask

    task automatic load_word(input logic [3:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic go();
        got.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && !done; i++)
            tick();
        chk(tag, done, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && result_valid; i++)
            tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; load_en = 1'b0; load_addr = 4'd0;
        load_data = 16'd0; result_ready = 1'b0;
        @(negedge clock);
        chk("rst_iin", iin, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_drop", drop_cnt, 0);
        resetn = 1'b1;
        tick();

        // Basic run
        load_word(4'd0, 16'h1001);
        load_word(4'd1, 16'h2002);
        load_word(4'd2, 16'hFFFF);
        result_ready = 1'b1;
        go();
        for (int k = 0; k < 4; k++) begin
            chk("basic_iin0", iin, 16'h1001);
            if (k == 3) chk("basic_valid_lo", result_valid, 0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk("basic_iin1", iin, 16'h2002);
            if (k == 0) chk("basic_valid_hi", result_valid, 1);
            tick();
        end
        chk("basic_done", done, 1);
        chk("basic_pc", pc, 2);
        chk("basic_iin_nop", iin, 16'h0000);
        chk("basic_busy", busy, 0);
        tick();
        chk("basic_cnt", got.size(), 2);
        if (got.size() == 2) begin
            chk("basic_r0", got[0], res(16'h1001));
            chk("basic_r1", got[1], res(16'h2002));
        end

        // Full FIFO
        for (int i = 0; i < 6; i++)
            load_word(4'(i), 16'h3000 + 16'(i));
        load_word(4'd6, 16'hFFFF);
        result_ready = 1'b0;
        go();
        for (int k = 0; k < 20; k++)
            tick();
`ifdef INSTR_SEQ_DROP_EN
        chk("drop_busy", busy, 1);
        chk("drop_iin", iin, 16'h3005);
        chk("drop_pc", pc, 5);
        chk("drop_cnt1", drop_cnt, 1);
        for (int k = 0; k < 4; k++)
            tick();
        chk("drop_done", done, 1);
        chk("drop_pc_end", pc, 6);
        chk("drop_cnt2", drop_cnt, 2);
        result_ready = 1'b1;
        drain();
        chk("drop_cnt_res", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("drop_res", got[i], res(16'h3000 + 16'(i)));
`else
        chk("full_busy", busy, 1);
        chk("full_iin_nop", iin, 16'h0000);
        chk("full_pc", pc, 4);
        chk("full_valid", result_valid, 1);
        for (int k = 0; k < 3; k++)
            tick();
        chk("full_still_busy", busy, 1);
        chk("full_pc_frozen", pc, 4);
        chk("full_drop0", drop_cnt, 0);
        result_ready = 1'b1;
        wait_done(100, "full_done_timeout");
        drain();
        chk("full_pc_end", pc, 6);
        chk("full_cnt", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            chk("full_res", got[i], res(16'h3000 + 16'(i)));
`endif

        // Wrap
        for (int i = 0; i < 16; i++)
            load_word(4'(i), 16'h4000 + 16'(i));
        result_ready = 1'b1;
        go();
        wait_done(200, "wrap_done_timeout");
        chk("wrap_pc", pc, 0);
        drain();
        chk("wrap_cnt", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk("wrap_res", got[i], res(16'h4000 + 16'(i)));

        // Reset mid-run: slot 2 of instruction 1
        go();
        for (int k = 0; k < 6; k++)
            tick();
        chk("mid_iin_pre", iin, 16'h4001);
        resetn = 1'b0;
        #1;
        chk("mid_iin_nop", iin, 16'h0000);
        chk("mid_valid", result_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_pc", pc, 0);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        go();
        wait_done(200, "rerun_done_timeout");
        drain();
        chk("rerun_cnt", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk("rerun_res", got[i], res(16'h4000 + 16'(i)));

        // Load and start while busy are ignored
        go();
        for (int k = 0; k < 9; k++)
            tick();
        load_en = 1'b1; load_addr = 4'd1; load_data = 16'hFFFF; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        wait_done(200, "busyld_done_timeout");
        drain();
        chk("busyld_cnt", got.size(), 16);
        chk("busyld_pc", pc, 0);

        // Same write in DONE is applied
        load_word(4'd1, 16'hFFFF);
        go();
        wait_done(50, "doneld_done_timeout");
        chk("doneld_pc", pc, 1);
        drain();
        chk("doneld_cnt", got.size(), 1);

        // Load and start in the same cycle: new word 0 is a halt
        got.delete();
        load_en = 1'b1; load_addr = 4'd0; load_data = 16'hFFFF; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        chk("ldst_done", done, 1);
        chk("ldst_busy", busy, 0);
        chk("ldst_pc", pc, 0);
        chk("ldst_valid", result_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
